// File: rtl/sequencer_controller.sv
// sequencer_controller: 8-step note sequencer driven by a rotary encoder.
// EDIT mode: the encoder position writes the note under the edit cursor, and a
// short press advances the cursor. PLAY mode: steps advance at a fixed tempo,
// each note is offered over valid/ready, and a gate pulse is produced per step.
// A long press toggles the mode.
// Optional feature macro SEQ_PREVIEW_EN: in EDIT, each pattern write offers the
// new note downstream with a gate pulse, as an audible preview.
module sequencer_controller #(
  parameter int NUM_STEPS         = 8,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int STEP_CYCLES       = 12_500_000,
  parameter int GATE_CYCLES       = 6_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_pressed,
  input  logic [2:0] rotary_position,
  input  logic       note_ready,
  output logic       mode,
  output logic [2:0] cursor,
  output logic [2:0] play_step,
  output logic [2:0] note,
  output logic       note_valid,
  output logic       gate
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int TW = $clog2(STEP_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] LP_LAST   = PW'(LONG_PRESS_CYCLES - 1);
  localparam logic [PW-1:0] LP_MAX    = PW'(LONG_PRESS_CYCLES);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LEN  = TW'(GATE_CYCLES);

  localparam logic [0:0] PLAY_ISSUE = 1'b0;
  localparam logic [0:0] PLAY_HOLD  = 1'b1;

  logic [1:0]    sync_q, sync_d;
  logic          db_level_q, db_level_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [PW-1:0] press_cnt_q, press_cnt_d;
  logic          long_evt, short_evt;

  logic          mode_q, mode_d;
  logic [0:0]    state_q, state_d;
  logic [2:0]    cursor_q, cursor_d;
  logic [2:0]    play_step_q, play_step_d;
  logic [2:0]    note_q, note_d;
  logic          note_valid_q, note_valid_d;
  logic          gate_q, gate_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    prev_pos_q, prev_pos_d;
  logic          pos_changed;
  logic [2:0]    pattern_q [NUM_STEPS];
  logic [2:0]    pattern_d [NUM_STEPS];

  // Button conditioning: synchronize, debounce, and classify presses by length.
  always_comb begin
    sync_d      = {sync_q[0], button_pressed};
    db_level_d  = db_level_q;
    db_cnt_d    = '0;
    press_cnt_d = '0;
    if (sync_q[1] != db_level_q) begin
      if (db_cnt_q == DB_LAST) db_level_d = sync_q[1];
      else                     db_cnt_d   = db_cnt_q + DW'(1);
    end
    if (db_level_q)
      press_cnt_d = (press_cnt_q == LP_MAX) ? LP_MAX : press_cnt_q + PW'(1);
    // Long press fires on the cycle the counter reaches its limit while held;
    // a release before that point is a short press.
    long_evt  = db_level_q && db_level_d && (press_cnt_q == LP_LAST);
    short_evt = db_level_q && !db_level_d && (press_cnt_q < LP_MAX);
  end

  // Mode, cursor, pattern edits and the PLAY step/handshake/gate sequencing.
  always_comb begin
    mode_d       = mode_q;
    state_d      = state_q;
    cursor_d     = cursor_q;
    play_step_d  = play_step_q;
    note_d       = note_q;
    note_valid_d = note_valid_q;
    gate_d       = gate_q;
    timer_d      = timer_q;
    prev_pos_d   = rotary_position;
    pattern_d    = pattern_q;
    pos_changed  = (rotary_position != prev_pos_q);

    if (!mode_q) begin
      // EDIT: writes land on the cursor as it was at the start of the cycle.
      if (pos_changed) pattern_d[cursor_q] = rotary_position;
      if (short_evt)   cursor_d = cursor_q + 3'd1;
`ifdef SEQ_PREVIEW_EN
      if (note_valid_q && note_ready) note_valid_d = 1'b0;
      if (timer_q < GATE_LEN) timer_d = timer_q + TW'(1);
      gate_d = gate_q && (timer_d < GATE_LEN);
      // A newer write restarts the preview with the new note.
      if (pos_changed) begin
        note_d       = rotary_position;
        note_valid_d = 1'b1;
        timer_d      = '0;
        gate_d       = (GATE_LEN != '0);
      end
`endif
      if (long_evt) begin
        mode_d       = 1'b1;
        state_d      = PLAY_ISSUE;
        play_step_d  = 3'd0;
        timer_d      = '0;
        note_d       = pattern_d[3'd0];
        note_valid_d = 1'b1;
        gate_d       = (GATE_LEN != '0);
      end
    end else begin
      // PLAY: gate tracks the step timer independently of the handshake.
      timer_d = (timer_q == STEP_LAST) ? '0 : timer_q + TW'(1);
      gate_d  = (timer_d < GATE_LEN);
      if (state_q == PLAY_ISSUE && note_ready) begin
        note_valid_d = 1'b0;
        state_d      = PLAY_HOLD;
      end
      // Step end: an untransferred note is abandoned and the next one offered.
      if (timer_q == STEP_LAST) begin
        play_step_d  = play_step_q + 3'd1;
        state_d      = PLAY_ISSUE;
        note_d       = pattern_q[play_step_q + 3'd1];
        note_valid_d = 1'b1;
      end
      if (long_evt) begin
        mode_d       = 1'b0;
        state_d      = PLAY_ISSUE;
        note_valid_d = 1'b0;
        gate_d       = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      db_level_q   <= 1'b0;
      db_cnt_q     <= '0;
      press_cnt_q  <= '0;
      mode_q       <= 1'b0;
      state_q      <= PLAY_ISSUE;
      cursor_q     <= '0;
      play_step_q  <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      gate_q       <= 1'b0;
      timer_q      <= '0;
      prev_pos_q   <= '0;
      pattern_q    <= '{default: '0};
    end else begin
      sync_q       <= sync_d;
      db_level_q   <= db_level_d;
      db_cnt_q     <= db_cnt_d;
      press_cnt_q  <= press_cnt_d;
      mode_q       <= mode_d;
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      play_step_q  <= play_step_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      gate_q       <= gate_d;
      timer_q      <= timer_d;
      prev_pos_q   <= prev_pos_d;
      pattern_q    <= pattern_d;
    end
  end

  assign mode       = mode_q;
  assign cursor     = cursor_q;
  assign play_step  = play_step_q;
  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign gate       = gate_q;

endmodule

// File: tb/tb_sequencer_controller.sv
// Testbench for sequencer_controller with short timing parameters.
// Expected notes are queued as stimulus is set up and compared on each transfer.
module tb_sequencer_controller;

  localparam int DB = 4;
  localparam int LP = 20;
  localparam int ST = 16;
  localparam int GT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       button_pressed;
  logic [2:0] rotary_position;
  logic       note_ready;
  logic       mode;
  logic [2:0] cursor;
  logic [2:0] play_step;
  logic [2:0] note;
  logic       note_valid;
  logic       gate;

  int         errors = 0;
  int         checks = 0;
  logic [2:0] sb [$];
  logic [2:0] exp_pat [8];
  int         exp_cursor;

  sequencer_controller #(
    .NUM_STEPS        (8),
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .STEP_CYCLES      (ST),
    .GATE_CYCLES      (GT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .button_pressed (button_pressed),
    .rotary_position(rotary_position),
    .note_ready     (note_ready),
    .mode           (mode),
    .cursor         (cursor),
    .play_step      (play_step),
    .note           (note),
    .note_valid     (note_valid),
    .gate           (gate)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted note must match the oldest expected note.
  always @(negedge clk) begin
    if (!rst && note_valid && note_ready) begin
      if (sb.size() == 0) check("xfer_pending", sb.size(), 1);
      else                check("xfer_note", note, sb.pop_front());
    end
  end

  task automatic short_press();
    button_pressed = 1'b1;
    repeat (10) tick();
    button_pressed = 1'b0;
    repeat (12) tick();
    exp_cursor = (exp_cursor + 1) % 8;
    check("cursor_step", cursor, exp_cursor);
    check("edit_mode", mode, 0);
  endtask

  task automatic set_pos(input logic [2:0] v);
    rotary_position = v;
    exp_pat[exp_cursor] = v;
`ifdef SEQ_PREVIEW_EN
    sb.push_back(v);
    tick();
    check("preview_valid", note_valid, 1);
    check("preview_note", note, v);
    note_ready = 1'b1;
    tick();
    note_ready = 1'b0;
    check("preview_done", note_valid, 0);
`else
    tick();
    tick();
    check("edit_valid", note_valid, 0);
    check("edit_gate", gate, 0);
`endif
  endtask

  task automatic long_press(input logic want_mode);
    int waited;
    waited = 0;
    button_pressed = 1'b1;
    while (mode !== want_mode && waited < 60) begin
      tick();
      waited++;
    end
    button_pressed = 1'b0;
    check("long_press_mode", mode, want_mode);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    button_pressed = 1'b0;
    note_ready = 1'b0;
    rotary_position = 3'd0;
    exp_cursor = 0;
    for (int k = 0; k < 8; k++) exp_pat[k] = 3'd0;

    // Reset state
    repeat (3) tick();
    check("rst_mode", mode, 0);
    check("rst_cursor", cursor, 0);
    check("rst_play_step", play_step, 0);
    check("rst_note", note, 0);
    check("rst_valid", note_valid, 0);
    check("rst_gate", gate, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Two-cycle glitch must not register as a press
    button_pressed = 1'b1;
    repeat (2) tick();
    button_pressed = 1'b0;
    repeat (12) tick();
    check("glitch_cursor", cursor, 0);
    check("glitch_mode", mode, 0);

    // Short presses: 0->1, up to 7, then eight more across the wrap
    short_press();
    repeat (6) short_press();
    repeat (8) short_press();
    repeat (3) short_press();

    // Pattern programming: cursor 2 gets 5, cursor 3 stays 0
    set_pos(3'd5);
    short_press();
    short_press(); set_pos(3'd7);
    short_press(); set_pos(3'd1);
    short_press(); set_pos(3'd6);
    short_press(); set_pos(3'd3);
    short_press(); set_pos(3'd5);
    short_press(); set_pos(3'd2);
    repeat (4) tick();

    // PLAY with note_ready held high: one transfer per step, wrap after 128
    note_ready = 1'b1;
    for (int k = 0; k < 9; k++) sb.push_back(exp_pat[k % 8]);
    long_press(1'b1);
    check("play_first_note", note, exp_pat[0]);
    for (int i = 0; i < 136; i++) begin
      check("play_gate", gate, (i % 16) < GT);
      check("play_step", play_step, (i / 16) % 8);
      if (i % 16 == 0) check("play_valid_start", note_valid, 1);
      if (i % 16 == 1) check("play_valid_after_xfer", note_valid, 0);
      tick();
    end
    check("play_sb_drain", sb.size(), 0);

    // Backpressure: a whole step without ready keeps the note offered and stable
    note_ready = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 16; i++) begin
      check("bp_valid", note_valid, 1);
      check("bp_note", note, exp_pat[1]);
      check("bp_step", play_step, 1);
      tick();
    end
    check("bp_next_step", play_step, 2);
    check("bp_next_valid", note_valid, 1);
    check("bp_next_note", note, exp_pat[2]);

    // Leave PLAY while a note is still being offered
    long_press(1'b0);
    check("exit_valid", note_valid, 0);
    check("exit_gate", gate, 0);
    repeat (12) tick();

`ifdef SEQ_PREVIEW_EN
    rotary_position = 3'd3;
    exp_pat[exp_cursor] = 3'd3;
    sb.push_back(3'd3);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("pv_valid", note_valid, 1);
      check("pv_note", note, 3);
      check("pv_gate", gate, i < GT);
      tick();
    end
    note_ready = 1'b1;
    tick();
    note_ready = 1'b0;
    check("pv_valid_done", note_valid, 0);
`else
    rotary_position = 3'd3;
    exp_pat[exp_cursor] = 3'd3;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("edit_idle_valid", note_valid, 0);
      check("edit_idle_gate", gate, 0);
      tick();
    end
`endif
    check("pv_sb_drain", sb.size(), 0);
    repeat (10) tick();

    // Asynchronous reset in the middle of PLAY
    note_ready = 1'b1;
    sb.push_back(exp_pat[0]);
    long_press(1'b1);
    check("replay_note", note, exp_pat[0]);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_mode", mode, 0);
    check("arst_gate", gate, 0);
    check("arst_valid", note_valid, 0);
    check("arst_cursor", cursor, 0);
    check("arst_play_step", play_step, 0);
    rotary_position = 3'd0;
    repeat (2) tick();
    rst = 1'b0;
    exp_cursor = 0;
    for (int k = 0; k < 8; k++) exp_pat[k] = 3'd0;
    check("arst_sb_drain", sb.size(), 0);
    repeat (4) tick();

    // Pattern must read back all zeros after reset
    for (int k = 0; k < 8; k++) sb.push_back(exp_pat[k]);
    long_press(1'b1);
    for (int i = 0; i < 128; i++) begin
      if (i % 16 == 0) check("zero_valid", note_valid, 1);
      tick();
    end
    check("zero_sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
